// File: rtl/rom_dl_pkg.sv
// rom_dl_pkg: shared state, FIFO entry type and region decode helper for the ROM download router
package rom_dl_pkg;
  localparam int DL_AW = 32;
  localparam logic [7:0] DROP_MAX = 8'd255;
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ISSUE, S_WAIT} dl_state_t;
  typedef struct packed {
    logic [DL_AW-1:0] addr;
    logic [7:0] data;
  } dl_entry_t;
  function automatic logic region_hit(input logic [DL_AW-1:0] addr, input logic [DL_AW-1:0] base, input logic [DL_AW-1:0] last);
    return addr >= base && addr <= last;
  endfunction
endpackage

// File: rtl/rom_dl_fifo.sv
// rom_dl_fifo: synchronous first-word-fall-through FIFO with full/empty flags
module rom_dl_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input logic clk_sys,
  input logic reset,
  input logic push,
  input logic pop,
  input logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && (!full || pop)) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/rom_dl_router.sv
// rom_dl_router: routes ioctl download bytes to SDRAM ports by address region; ROM_DL_WORD_PACK_EN merges even/odd byte pairs
module rom_dl_router
  import rom_dl_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W = 25,
  parameter int PORT_AW = 23,
  parameter int FIFO_DEPTH = 4,
  parameter logic [NUM_PORTS*ADDR_W-1:0] REGION_BASE = {25'h10000, 25'h0},
  parameter logic [NUM_PORTS*ADDR_W-1:0] REGION_END = {25'h243FF, 25'h0FFFF}
) (
  input logic clk_sys,
  input logic reset,
  input logic ioctl_downl,
  input logic ioctl_wr,
  input logic [ADDR_W-1:0] ioctl_addr,
  input logic [7:0] ioctl_dout,
  output logic [NUM_PORTS-1:0] port_req,
  input logic [NUM_PORTS-1:0] port_ack,
  output logic [NUM_PORTS*PORT_AW-1:0] port_a,
  output logic [NUM_PORTS*2-1:0] port_ds,
  output logic [NUM_PORTS*16-1:0] port_d,
  output logic [NUM_PORTS-1:0] port_we,
  output logic rom_loaded,
  output logic core_reset,
  output logic overflow,
  output logic [7:0] drop_cnt
);
  localparam int SW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  dl_state_t st, nxt;
  dl_entry_t fifo_dout, hold;
  logic wr_q, downl_q, busy, push, pop, full, empty, hit, drop, drained;
  logic [SW-1:0] hit_idx, iss_sel;
  logic [DL_AW-1:0] base_sel;
  logic [PORT_AW:0] lcl;
  logic [PORT_AW-1:0] iss_a;
  logic [1:0] iss_ds;
  logic [15:0] iss_d;
`ifdef ROM_DL_WORD_PACK_EN
  logic pk_valid, replay, pair, flush, stash, pk_drain;
  logic [SW-1:0] pk_sel;
  logic [PORT_AW:0] pk_lcl;
  logic [7:0] pk_data;
  assign pair = pk_valid && hit && hit_idx == pk_sel && lcl == pk_lcl + 1'b1;
  assign flush = pk_valid && !pair;
  assign stash = !pk_valid && hit && !lcl[0];
  assign pk_drain = st == S_IDLE && empty && pk_valid && !ioctl_downl;
  assign drop = st == S_DECODE && !hit && !pk_valid;
  assign drained = st == S_IDLE && empty && port_ack == port_req && !pk_valid;
`else
  assign drop = st == S_DECODE && !hit;
  assign drained = st == S_IDLE && empty && port_ack == port_req;
`endif
  assign push = ioctl_downl && ioctl_wr && !wr_q;
  assign port_we = {NUM_PORTS{ioctl_downl | busy}};
  assign lcl = (PORT_AW+1)'(hold.addr - base_sel);
  rom_dl_fifo #(.W($bits(dl_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys,
    .reset,
    .push,
    .pop,
    .din({DL_AW'(ioctl_addr), ioctl_dout}),
    .dout(fifo_dout),
    .full,
    .empty
  );
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    base_sel = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (region_hit(hold.addr, DL_AW'(REGION_BASE[i*ADDR_W +: ADDR_W]), DL_AW'(REGION_END[i*ADDR_W +: ADDR_W]))) begin
        hit = 1'b1;
        hit_idx = SW'(i);
        base_sel = DL_AW'(REGION_BASE[i*ADDR_W +: ADDR_W]);
      end
  end
  always_ff @(posedge clk_sys) st <= reset ? S_IDLE : nxt;
  always_comb begin
    nxt = st;
    pop = 1'b0;
    case (st)
      S_IDLE: begin
        pop = !empty;
`ifdef ROM_DL_WORD_PACK_EN
        nxt = !empty ? S_DECODE : pk_drain ? S_ISSUE : S_IDLE;
`else
        nxt = !empty ? S_DECODE : S_IDLE;
`endif
      end
`ifdef ROM_DL_WORD_PACK_EN
      S_DECODE: nxt = (flush || pair || (hit && !stash)) ? S_ISSUE : S_IDLE;
      S_WAIT: nxt = port_ack[iss_sel] == port_req[iss_sel] ? (replay ? S_DECODE : S_IDLE) : S_WAIT;
`else
      S_DECODE: nxt = hit ? S_ISSUE : S_IDLE;
      S_WAIT: nxt = port_ack[iss_sel] == port_req[iss_sel] ? S_IDLE : S_WAIT;
`endif
      S_ISSUE: nxt = S_WAIT;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_sys) begin
    wr_q <= ioctl_wr;
    downl_q <= ioctl_downl;
    core_reset <= reset | ioctl_downl | ~rom_loaded;
    if (reset) begin
      hold <= '0;
      iss_sel <= '0;
      iss_a <= '0;
      iss_ds <= '0;
      iss_d <= '0;
      port_req <= port_ack;
      port_a <= '0;
      port_ds <= '0;
      port_d <= '0;
      rom_loaded <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      busy <= 1'b0;
`ifdef ROM_DL_WORD_PACK_EN
      pk_valid <= 1'b0;
      replay <= 1'b0;
      pk_sel <= '0;
      pk_lcl <= '0;
      pk_data <= '0;
`endif
    end else begin
      if (pop) hold <= fifo_dout;
      if (st == S_DECODE) begin
        iss_sel <= hit_idx;
        iss_a <= lcl[PORT_AW:1];
        iss_ds <= {lcl[0], ~lcl[0]};
        iss_d <= {2{hold.data}};
      end
`ifdef ROM_DL_WORD_PACK_EN
      if (st == S_DECODE) replay <= flush;
      if ((st == S_DECODE && flush) || pk_drain) begin
        iss_sel <= pk_sel;
        iss_a <= pk_lcl[PORT_AW:1];
        iss_ds <= {pk_lcl[0], ~pk_lcl[0]};
        iss_d <= {2{pk_data}};
        pk_valid <= 1'b0;
      end else if (st == S_DECODE && pair) begin
        iss_sel <= pk_sel;
        iss_a <= pk_lcl[PORT_AW:1];
        iss_ds <= 2'b11;
        iss_d <= {hold.data, pk_data};
        pk_valid <= 1'b0;
      end else if (st == S_DECODE && stash) begin
        pk_valid <= 1'b1;
        pk_sel <= hit_idx;
        pk_lcl <= lcl;
        pk_data <= hold.data;
      end
`endif
      if (st == S_ISSUE) begin
        port_a[iss_sel*PORT_AW +: PORT_AW] <= iss_a;
        port_ds[iss_sel*2 +: 2] <= iss_ds;
        port_d[iss_sel*16 +: 16] <= iss_d;
        port_req[iss_sel] <= ~port_req[iss_sel];
      end
      if (drop && drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      if (ioctl_downl) busy <= 1'b1;
      else if (busy && drained) begin
        busy <= 1'b0;
        rom_loaded <= 1'b1;
      end
      if (ioctl_downl && !downl_q) begin
        rom_loaded <= 1'b0;
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_rom_dl_router.sv
// tb_rom_dl_router: directed and randomized checks of the ROM download router against a region-map model
module tb_rom_dl_router;
  typedef struct packed {
    logic port;
    logic [22:0] a;
    logic [1:0] ds;
    logic [15:0] d;
  } wr_t;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic ioctl_downl = 1'b0;
  logic ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_dout = '0;
  logic [1:0] port_req;
  logic [1:0] port_ack = '0;
  logic [1:0] port_we;
  logic [45:0] port_a;
  logic [3:0] port_ds;
  logic [31:0] port_d;
  logic rom_loaded, core_reset, overflow;
  logic [7:0] drop_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  int lat = 3;
  int exp_drop = 0;
  int exp_ovf = 0;
  bit ack_hold = 1'b0;
  int ack_cnt [2] = '{0, 0};
  logic [1:0] req_prev = '0;
  wr_t exp_q[$];
  wr_t obs_q[$];
  int unsigned base_tab [2] = '{32'h0, 32'h10000};
  int unsigned last_tab [2] = '{32'hFFFF, 32'h243FF};

  always #5 clk_sys = ~clk_sys;

  rom_dl_router dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ioctl_downl(ioctl_downl),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .port_req(port_req),
    .port_ack(port_ack),
    .port_a(port_a),
    .port_ds(port_ds),
    .port_d(port_d),
    .port_we(port_we),
    .rom_loaded(rom_loaded),
    .core_reset(core_reset),
    .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always @(posedge clk_sys)
    for (int i = 0; i < 2; i++)
      if (!reset && port_req[i] !== port_ack[i] && !ack_hold) begin
        if (ack_cnt[i] >= lat - 1) begin
          port_ack[i] <= port_req[i];
          ack_cnt[i] <= 0;
        end else ack_cnt[i] <= ack_cnt[i] + 1;
      end else ack_cnt[i] <= 0;

  always @(negedge clk_sys) begin : mon
    wr_t w;
    if (!reset)
      for (int i = 0; i < 2; i++)
        if (port_req[i] !== req_prev[i]) begin
          w.port = i[0];
          w.a = port_a[i*23 +: 23];
          w.ds = port_ds[i*2 +: 2];
          w.d = port_d[i*16 +: 16];
          obs_q.push_back(w);
        end
    req_prev <= port_req;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic void model_wr(input logic [24:0] a, input logic [7:0] d);
    wr_t w;
    int unsigned off;
    for (int i = 0; i < 2; i++)
      if (32'(a) >= base_tab[i] && 32'(a) <= last_tab[i]) begin
        off = 32'(a) - base_tab[i];
        w.port = i[0];
        w.a = 23'(off / 2);
        w.ds = off % 2 == 1 ? 2'b10 : 2'b01;
        w.d = {d, d};
        exp_q.push_back(w);
        return;
      end
    if (exp_drop < 255) exp_drop++;
  endfunction

  function automatic logic [24:0] rnd_addr();
    case ($urandom_range(0, 7))
      0: return 25'($urandom_range(0, 32'hFFFF));
      1: return 25'h0FFFF;
      2: return 25'h10000;
      3: return 25'($urandom_range(32'h10000, 32'h243FF));
      4: return 25'h243FF;
      5: return 25'h24400;
      6: return 25'($urandom_range(32'h24400, 32'h1FFFFFF));
      default: return 25'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input int gap, input bit keep);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    @(posedge clk_sys);
    #1;
    ioctl_wr = 1'b0;
    if (keep) model_wr(a, d);
    repeat (gap) @(posedge clk_sys);
    #1;
  endtask

  task automatic cmp_writes(input string tag);
    check({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) check({tag, "_wr"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic begin_dl(input string tag);
    ioctl_downl = 1'b1;
    @(posedge clk_sys);
    #1;
    check({tag, "_loaded_clr"}, 64'(rom_loaded), 64'(0));
    check({tag, "_drop_clr"}, 64'(drop_cnt), 64'(0));
    check({tag, "_ovf_clr"}, 64'(overflow), 64'(0));
    check({tag, "_core_rst_dl"}, 64'(core_reset), 64'(1));
    exp_drop = 0;
    exp_ovf = 0;
  endtask

  task automatic finish_dl(input string tag);
    int n = 0;
    ioctl_downl = 1'b0;
    while (!rom_loaded && n < 500) begin
      @(negedge clk_sys);
      n++;
    end
    check({tag, "_loaded"}, 64'(rom_loaded), 64'(1));
    check({tag, "_core_rst_lag"}, 64'(core_reset), 64'(1));
    check({tag, "_we_off"}, 64'(port_we), 64'(0));
    @(negedge clk_sys);
    check({tag, "_core_rst_rel"}, 64'(core_reset), 64'(0));
    check({tag, "_drop"}, 64'(drop_cnt), 64'(exp_drop));
    check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    cmp_writes(tag);
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk_sys);
    #1;
    check("rst_req", 64'(port_req), 64'(port_ack));
    check("rst_a", 64'(port_a), 64'(0));
    check("rst_ds", 64'(port_ds), 64'(0));
    check("rst_d", 64'(port_d), 64'(0));
    check("rst_loaded", 64'(rom_loaded), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check("rst_drop", 64'(drop_cnt), 64'(0));
    check("rst_core", 64'(core_reset), 64'(1));
    check("rst_we", 64'(port_we), 64'(0));
    reset = 1'b0;
    repeat (5) @(posedge clk_sys);
    #1;
    check("idle_loaded", 64'(rom_loaded), 64'(0));
    check("idle_core", 64'(core_reset), 64'(1));

    lat = 3;
    begin_dl("dir");
    check("dir_we_on", 64'(port_we), 64'(3));
    for (int i = 0; i < 4; i++) wr_byte(25'(i), 8'(i), 10, 1'b1);
    wr_byte(25'h10004, 8'hA5, 10, 1'b1);
    wr_byte(25'h30000, 8'h5A, 10, 1'b1);
    finish_dl("dir");

    lat = int'($urandom_range(1, 4));
    begin_dl("rnd");
    for (int k = 0; k < 40; k++) wr_byte(rnd_addr(), 8'($urandom), 8 + int'($urandom_range(0, 4)), 1'b1);
    finish_dl("rnd");

    lat = 2;
    begin_dl("ovf");
    ack_hold = 1'b1;
    for (int k = 0; k < 6; k++) wr_byte(25'h100 + 25'(k), 8'(192 + k), 3, k < 5);
    check("ovf_flag", 64'(overflow), 64'(1));
    exp_ovf = 1;
    repeat (40) @(posedge clk_sys);
    #1;
    check("ovf_held", 64'(obs_q.size()), 64'(1));
    ack_hold = 1'b0;
    finish_dl("ovf");

    begin_dl("fall");
    ack_hold = 1'b1;
    for (int k = 0; k < 3; k++) wr_byte(25'h10200 + 25'(k), 8'(16 + k), 3, 1'b1);
    ioctl_downl = 1'b0;
    repeat (10) @(posedge clk_sys);
    #1;
    check("fall_not_loaded", 64'(rom_loaded), 64'(0));
    check("fall_we_busy", 64'(port_we), 64'(3));
    ack_hold = 1'b0;
    finish_dl("fall");

    begin_dl("sat");
    for (int k = 0; k < 260; k++) wr_byte(25'h30000 + 25'(k), 8'(k), 3, 1'b1);
    finish_dl("sat");

    begin_dl("rst");
    ack_hold = 1'b1;
    wr_byte(25'h20, 8'h77, 3, 1'b1);
    wr_byte(25'h21, 8'h88, 3, 1'b0);
    reset = 1'b1;
    ioctl_downl = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    check("rst_mid_loaded", 64'(rom_loaded), 64'(0));
    check("rst_mid_core", 64'(core_reset), 64'(1));
    check("rst_mid_req", 64'(port_req), 64'(port_ack));
    reset = 1'b0;
    ack_hold = 1'b0;
    @(posedge clk_sys);
    #1;
    begin_dl("rst2");
    wr_byte(25'h22, 8'h99, 10, 1'b1);
    finish_dl("rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rom_dl_router.md
Name: rom_dl_router

Overview:
- Parametrised successor to the single-pair ioctl→SDRAM download toggler in the arcade top-levels.
- Captures bytes from the data_io download stream into a small FIFO and decodes each address against NUM_PORTS address regions.
- Issues toggle-handshake writes to the matching SDRAM port with region-relative addressing, and waits for ack before the next write.
- Generates rom_loaded and a core-hold reset; sits between data_io and sdram in every core top.

Parameters:
- NUM_PORTS, 2, number of SDRAM write ports/regions.
- ADDR_W, 25, ioctl address width.
- PORT_AW, 23, port word-address width.
- FIFO_DEPTH, 4, capture FIFO entries (power of two, ≥2).
- REGION_BASE, {25'h10000, 25'h0}, packed NUM_PORTS×ADDR_W inclusive region starts, index 0 in the LSBs.
- REGION_END, {25'h243FF, 25'h0FFFF}, packed NUM_PORTS×ADDR_W inclusive region ends.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ioctl_downl  in  1  download active.
- ioctl_wr  in  1  byte strobe, level; rising edge is a write.
- ioctl_addr  in  ADDR_W  byte address.
- ioctl_dout  in  8  byte data.
- port_req  out  NUM_PORTS  per-port request toggle.
- port_ack  in  NUM_PORTS  per-port ack toggle.
- port_a  out  NUM_PORTS×PORT_AW  word address per port.
- port_ds  out  NUM_PORTS×2  byte strobes {hi,lo}.
- port_d  out  NUM_PORTS×16  write data.
- port_we  out  NUM_PORTS  write enable, held high while ioctl_downl or the drain is busy.
- rom_loaded  out  1  set after a complete, drained download.
- core_reset  out  1  hold for game core.
- overflow  out  1  sticky: write lost because the FIFO was full.
- drop_cnt  out  8  count of unmapped writes; saturating.

Behaviour:
- Reset values:
  - FIFO empty; state IDLE.
  - port_req loads port_ack, so no spurious request is issued.
  - port_a, port_ds, port_d zero.
  - rom_loaded 0, overflow 0, drop_cnt 0, core_reset 1.
- Capture:
  - ioctl_wr is registered. A 0→1 edge while ioctl_downl=1 pushes {addr,data} in the next cycle.
  - Edges while ioctl_downl=0 are ignored.
  - Push while full: the write is discarded and overflow sets.
  - Simultaneous push and pop is allowed when full.
- FSM IDLE→DECODE→ISSUE→WAIT→IDLE:
  - IDLE: on FIFO non-empty, pop the head into the holding register and go to DECODE.
  - DECODE: the lowest index i with BASE[i] ≤ addr ≤ END[i] wins.
    - No hit: drop_cnt++ (saturates at 255), go to IDLE.
    - Hit: local = addr − BASE[i], go to ISSUE.
  - ISSUE: port_a[i] = local[PORT_AW:1], port_ds[i] = {local[0], ~local[0]}, port_d[i] = {data,data}; port_req[i] toggles. Go to WAIT.
  - WAIT: stay until port_ack[i] == port_req[i], then go to IDLE. No timeout.
  - Minimum throughput is one byte per 4 cycles plus SDRAM latency.
- Outputs of non-selected ports hold their last value.
- Download lifecycle:
  - A 0→1 edge of ioctl_downl clears rom_loaded, overflow and drop_cnt.
  - rom_loaded sets once ioctl_downl=0, the FIFO is empty and the FSM is in IDLE with no outstanding ack (drain complete).
  - core_reset = reset | ioctl_downl | ~rom_loaded, registered (1-cycle latency).
- Reset mid-transfer: the in-flight write is abandoned, the FIFO is flushed and rom_loaded clears. The host must restart the download.

Optional Feature:
- Macro: ROM_DL_WORD_PACK_EN.
- Defined:
  - An even-address byte is held in a pack register.
  - If the next write is the odd byte at addr+1 in the same region, one request is issued with ds=2'b11 and d={odd,even}.
  - Otherwise the pending even byte is flushed as a single-byte write first.
  - The pending byte is also flushed when ioctl_downl falls, before rom_loaded sets.
- Undefined: one request per byte, exactly as in Behaviour.

Decomposition:
- Package rom_dl_pkg:
  - state enum.
  - FIFO entry struct {addr, data}.
  - Function region_hit(addr, base, end).
  - Constant DROP_MAX=255.
- Sub-module rom_dl_fifo: synchronous FIFO parametrised by width and depth, with full/empty flags, first-word-fall-through.

Test Plan:
- Bytes 0x00..0x03 at addr 0x0000–0x0003, ack after 3 cycles → port 0:
  - a = 0, 0, 1, 1.
  - ds = 01, 10, 01, 10.
  - d = {b,b}.
  - Four req toggles.
- Byte 0xA5 at addr 0x10004 → port 1 with a = 0x2, ds = 01, d = 16'hA5A5; port 0 req unchanged.
- addr 0x30000 (unmapped) → no req toggle on any port; drop_cnt = 1.
- Ack withheld for 40 cycles while 6 strobes arrive → FIFO holds 4, overflow = 1, remaining writes complete after ack.
- ioctl_downl falls with 2 entries queued → rom_loaded stays 0 until both acks arrive; core_reset falls 1 cycle after rom_loaded rises.
- With ROM_DL_WORD_PACK_EN: bytes 0x11@0x0, 0x22@0x1, 0x33@0x2, then download end → two requests:
  - a = 0, ds = 11, d = 16'h2211.
  - a = 1, ds = 01, d = 16'h3333.
